// File: rtl/stopwatch_pkg.sv
`default_nettype none
// stopwatch_pkg: shared state encoding, BCD digit limits and time-of-count record for the stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_LAP  = 2'd3
  } state_t;

  localparam logic [3:0] TENTHS_MAX   = 4'd9;
  localparam logic [3:0] SEC_ONES_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  typedef struct packed {
    logic [3:0] min;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] tenths;
  } bcd_time_t;

  function automatic logic [3:0] bcd_step(input logic [3:0] digit, input logic wrap);
    return wrap ? 4'd0 : digit + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// btn_sync_edge: SYNC_STAGES-deep synchronizer followed by a one-cycle rising-edge pulse.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk5,
  input  logic reset,
  input  logic btn_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Decoded from registers only, so the pulse is consumed at edge k+SYNC_STAGES.
  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// stopwatch_ctrl: run/stop/lap FSM driving an M:SS.t BCD count to the display.
// Define STOPWATCH_OVF_STOP_EN to saturate at MIN_MAX:59.9, force STOP and raise a sticky ovf.
module stopwatch_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_MAX     = 9
) (
  input  logic       clk5,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic [3:0] disp_tenths,
  output logic [3:0] disp_sec_ones,
  output logic [3:0] disp_sec_tens,
  output logic [3:0] disp_min,
  output logic       running,
  output logic       lap_active,
  output logic       ovf
);

  import stopwatch_pkg::*;

  localparam logic [3:0] MIN_MAX_BCD = 4'(MIN_MAX);

  state_t    state_q, state_d;
  bcd_time_t live_q, live_d;
  bcd_time_t lap_q, lap_d;
  bcd_time_t shown;

  logic ss_ev, lr_ev;
  logic count_en, carry_t, carry_so, carry_st, ovf_hit, sat_hold;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
    .clk5       (clk5),
    .reset      (reset),
    .btn_in     (btn_ss),
    .rise_pulse (ss_ev)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lr (
    .clk5       (clk5),
    .reset      (reset),
    .btn_in     (btn_lr),
    .rise_pulse (lr_ev)
  );

  // Counting follows the registered state, so a tick on the edge entering RUN is not counted.
  assign count_en = tick && (state_q == ST_RUN || state_q == ST_LAP);
  assign carry_t  = count_en && (live_q.tenths == TENTHS_MAX);
  assign carry_so = carry_t && (live_q.sec_ones == SEC_ONES_MAX);
  assign carry_st = carry_so && (live_q.sec_tens == SEC_TENS_MAX);
  assign ovf_hit  = carry_st && (live_q.min == MIN_MAX_BCD);

`ifdef STOPWATCH_OVF_STOP_EN
  assign sat_hold = ovf_hit;
`else
  assign sat_hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ss_ev) state_d = ST_RUN;
      ST_RUN:  if (ss_ev) state_d = ST_STOP; else if (lr_ev) state_d = ST_LAP;
      ST_LAP:  if (ss_ev) state_d = ST_STOP; else if (lr_ev) state_d = ST_RUN;
      ST_STOP: if (ss_ev) state_d = ST_RUN;  else if (lr_ev) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (sat_hold) state_d = ST_STOP;
  end

  always_comb begin
    live_d = live_q;
    lap_d  = lap_q;
    if (state_q == ST_STOP && state_d == ST_IDLE) begin
      live_d = '0;
    end else if (count_en && !sat_hold) begin
      live_d.tenths = bcd_step(live_q.tenths, carry_t);
      if (carry_t)  live_d.sec_ones = bcd_step(live_q.sec_ones, carry_so);
      if (carry_so) live_d.sec_tens = bcd_step(live_q.sec_tens, carry_st);
      if (carry_st) live_d.min      = bcd_step(live_q.min, ovf_hit);
    end
    // Lap-hold captures the pre-increment count of the edge that enters LAP.
    if (state_q == ST_RUN && state_d == ST_LAP) lap_d = live_q;
  end

  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      live_q  <= '0;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
      lap_q   <= lap_d;
    end
  end

`ifdef STOPWATCH_OVF_STOP_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_hit)            ovf_d = 1'b1;
    if (state_d == ST_IDLE) ovf_d = 1'b0;
  end

  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign shown         = (state_q == ST_LAP) ? lap_q : live_q;
  assign disp_tenths   = shown.tenths;
  assign disp_sec_ones = shown.sec_ones;
  assign disp_sec_tens = shown.sec_tens;
  assign disp_min      = shown.min;
  assign running       = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign lap_active    = (state_q == ST_LAP);

endmodule
`default_nettype wire
